id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage RISC-V core; sits directly upstream of the ALU.
- Captures decoded operands and control from ID, inserts load-use bubbles and flush bubbles, and holds on downstream stall.
- Applies EX/MEM and MEM/WB forwarding so that the ALU receives final data1/data2 operands and ALU control.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- stall_i  in  1  downstream stall: hold all EX registers
- flush_i  in  1  branch taken: replace the EX contents with a bubble
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register addresses
- id_rs2_used_i  in  1  instruction reads rs2 (R-type, store, beq)
- id_alu_ctrl_i  in  4  ALU operation code (pkg encoding)
- id_alu_src_i  in  1  1 = operand 2 is the immediate
- id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i  in  1  control
- exmem_reg_write_i  in  1; exmem_rd_i  in  5; exmem_data_i  in  XLEN  EX/MEM forward source
- memwb_reg_write_i  in  1; memwb_rd_i  in  5; memwb_data_i  in  XLEN  MEM/WB forward source
- hazard_o  out  1  load-use hazard: IF/ID and PC must hold this cycle
- ex_valid_o  out  1  EX holds a real instruction
- alu_data1_o, alu_data2_o  out  XLEN  ALU operands
- alu_ctrl_o  out  4  to the ALU
- ex_store_data_o  out  XLEN  forwarded rs2 for sw
- ex_rd_o  out  5; ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o  out  1
- bubble_cnt_o  out  CNT_W  count of inserted hazard bubbles

Behaviour:
- Reset (rst_i==0 at an edge): all EX registers are 0, ex_valid_o=0, bubble_cnt_o=0.
  - Combinational outputs then read 0 except where forwarding selects a source; hazard_o=0.
- Register update priority per edge: reset > flush_i > stall_i > hazard bubble > load.
  - flush: valid and all control bits 0; data fields don't-care (driven 0).
  - stall: every EX register holds, including the counter. A hazard present in the same cycle is not bubbled; ID re-presents it.
  - hazard bubble: same as flush, and bubble_cnt increments.
  - load: all id_* captured. Control bits are ANDed with id_valid_i.
- hazard_o, combinational:
  - ex_valid & ex_mem_read & ex_rd!=0 & id_valid_i
  - & (ex_rd==id_rs1_i | (id_rs2_used_i & ex_rd==id_rs2_i))
  - Forced to 0 while flush_i=1.
- Forwarding, combinational, applied to the registered rs1 and rs2:
  - EX/MEM wins if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs.
  - Else MEM/WB wins under the same test.
  - Else the registered read data is used. x0 is never forwarded.
- Operand outputs:
  - alu_data2_o = alu_src ? imm : fwd_rs2.
  - ex_store_data_o is always fwd_rs2.
  - alu_data1_o = fwd_rs1.
- The WB-write/ID-read collision in the same cycle is resolved by the register file (write-first), not here.
- bubble_cnt saturates at all-ones and does not wrap.
- Latency: one cycle from ID capture to ALU operands valid.

Decomposition:
- Package riscv_pkg holds:
  - ALU_CTRL_W=4.
  - Codes AND=0, XOR=1, SLL=2, ADD=3, SUB=4, MUL=5, ADDI=6, SRAI=7, LW=8, SW=9, BEQ=10.
  - The REG_ADDR_W=5 constant.
  - A struct for the EX control bundle.
- One sub-module, forward_unit: purely combinational mux select for one operand. Instantiated twice.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with id_valid_i=1 -> ex_valid_o=0, all control 0, bubble_cnt_o=0.
- EX/MEM forward:
  - Stimulus: add x3 in EX; exmem_rd=3, exmem_data=0x0000_0055, reg_write=1; memwb_rd=3, data=0x11.
  - Required: alu_data1_o=0x55 (EX/MEM priority over MEM/WB).
- Load-use:
  - Stimulus: lw x5 in EX, then ID presents add with rs2=5, rs2_used=1.
  - Required: hazard_o=1; next edge ex_valid_o=0 and bubble_cnt_o=1; following cycle the add loads normally.
- x0 guard: exmem_rd=0, reg_write=1, data=0xDEAD and rs1=0 in EX -> alu_data1_o equals the registered value 0.
- Stall vs flush:
  - stall_i=1 for 3 cycles -> EX outputs unchanged.
  - stall_i=1 and flush_i=1 together -> next edge ex_valid_o=0 (flush wins).
- Counter saturation: CNT_W=2, force 5 hazard bubbles -> bubble_cnt_o=3 and stays 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types: ALU op codes, address widths, EX control bundle
package riscv_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_XOR  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_MUL  = 4'd5,
    ALU_ADDI = 4'd6,
    ALU_SRAI = 4'd7,
    ALU_LW   = 4'd8,
    ALU_SW   = 4'd9,
    ALU_BEQ  = 4'd10
  } alu_ctrl_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand bypass select for one source register (EX/MEM over MEM/WB over RF)
module forward_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]       exmem_data_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]       memwb_data_i,
  output logic [XLEN-1:0]       fwd_data_o
);

  always_comb begin
    fwd_data_o = rf_data_i;
    // x0 is hardwired to zero, so a pending write to it must never be bypassed
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
      fwd_data_o = exmem_data_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
      fwd_data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling, flush, stall and operand forwarding
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rs2_used_i,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl_i,
  input  logic                  id_alu_src_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_to_reg_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]       exmem_data_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]       memwb_data_i,
  output logic                  hazard_o,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       alu_data1_o,
  output logic [XLEN-1:0]       alu_data2_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic [XLEN-1:0]       ex_store_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_to_reg_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                  alu_src_q,  alu_src_d;
  ex_ctrl_t              ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

  logic                  load_use;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;

  always_comb begin
    load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid_i &&
               ((rd_q == id_rs1_i) || (id_rs2_used_i && (rd_q == id_rs2_i)));
  end

  assign hazard_o = load_use && !flush_i;

  always_comb begin
    valid_d      = valid_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_src_d    = alu_src_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i || (!stall_i && load_use)) begin
      valid_d    = 1'b0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      alu_ctrl_d = '0;
      alu_src_d  = 1'b0;
      ctrl_d     = '0;
      // Only load-use bubbles are counted; branch flushes are not stalls
      if (!flush_i && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (!stall_i) begin
      valid_d           = id_valid_i;
      rs1_data_d        = id_rs1_data_i;
      rs2_data_d        = id_rs2_data_i;
      imm_d             = id_imm_i;
      rs1_d             = id_rs1_i;
      rs2_d             = id_rs2_i;
      rd_d              = id_rd_i;
      alu_ctrl_d        = id_alu_ctrl_i;
      alu_src_d         = id_alu_src_i;
      ctrl_d.mem_read   = id_mem_read_i   && id_valid_i;
      ctrl_d.mem_write  = id_mem_write_i  && id_valid_i;
      ctrl_d.reg_write  = id_reg_write_i  && id_valid_i;
      ctrl_d.mem_to_reg = id_mem_to_reg_i && id_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q      <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  forward_unit #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_i              (rs1_q),
    .rf_data_i         (rs1_data_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_data_i      (exmem_data_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .fwd_data_o        (fwd_rs1)
  );

  forward_unit #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_i              (rs2_q),
    .rf_data_i         (rs2_data_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_data_i      (exmem_data_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .fwd_data_o        (fwd_rs2)
  );

  assign alu_data1_o     = fwd_rs1;
  assign alu_data2_o     = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data_o = fwd_rs2;
  assign alu_ctrl_o      = alu_ctrl_q;
  assign ex_valid_o      = valid_q;
  assign ex_rd_o         = rd_q;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage: reset, forwarding, x0, load-use, stall/flush, saturation
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i, stall_i, flush_i, id_valid_i;
  logic [XLEN-1:0]  id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
  logic             id_rs2_used_i, id_alu_src_i;
  logic [3:0]       id_alu_ctrl_i;
  logic             id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i;
  logic             exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]       exmem_rd_i, memwb_rd_i;
  logic [XLEN-1:0]  exmem_data_i, memwb_data_i;
  logic             hazard_o, ex_valid_o;
  logic [XLEN-1:0]  alu_data1_o, alu_data2_o, ex_store_data_o;
  logic [3:0]       alu_ctrl_o;
  logic [4:0]       ex_rd_o;
  logic             ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs2_used_i(id_rs2_used_i), .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .hazard_o(hazard_o), .ex_valid_o(ex_valid_o), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o), .ex_store_data_o(ex_store_data_o),
    .ex_rd_o(ex_rd_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        mr, mw, rw, m2r;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t observe();
    observe = '{ex_valid_o, alu_ctrl_o, alu_data1_o, alu_data2_o, ex_store_data_o,
                ex_rd_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o};
  endfunction

  function automatic obs_t mk(input logic v, input logic [3:0] c, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] st, input logic [4:0] rd,
                              input logic mr, input logic mw, input logic rw, input logic m2r);
    mk = '{v, c, d1, d2, st, rd, mr, mw, rw, m2r};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_idle();
    id_valid_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_rs2_used_i = 0;
    id_alu_ctrl_i = 0; id_alu_src_i = 0;
    id_mem_read_i = 0; id_mem_write_i = 0; id_reg_write_i = 0; id_mem_to_reg_i = 0;
  endtask

  task automatic fwd_clear();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [3:0] ctrl, input logic src, input logic used,
                          input logic mr, input logic mw, input logic rw, input logic m2r);
    id_valid_i = 1; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
    id_alu_ctrl_i = ctrl; id_alu_src_i = src; id_rs2_used_i = used;
    id_mem_read_i = mr; id_mem_write_i = mw; id_reg_write_i = rw; id_mem_to_reg_i = m2r;
  endtask

  task automatic do_reset();
    rst_i = 0; stall_i = 0; flush_i = 0;
    id_idle();
    fwd_clear();
    tick();
    tick();
    rst_i = 1;
  endtask

  task automatic test_reset();
    rst_i = 0; stall_i = 0; flush_i = 0;
    fwd_clear();
    id_instr(5'd1, 5'd2, 5'd3, 32'h12, 32'h34, 32'h56, ALU_LW, 1, 1, 1, 0, 1, 1);
    tick();
    tick();
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
    checks++; if ({ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000",
                           {ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o});
    end
    checks++; if (bubble_cnt_o !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt_o); end
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", hazard_o); end
    checks++; if (alu_data1_o !== 32'h0 || alu_data2_o !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", alu_data1_o, alu_data2_o);
    end
    rst_i = 1;
  endtask

  task automatic test_forward();
    logic        ex_rw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  ex_rd [5] = '{5'd3, 5'd3, 5'd2, 5'd9, 5'd2};
    logic [31:0] ex_d  [5] = '{32'h55, 32'h55, 32'hAA, 32'hAA, 32'hAA};
    logic        wb_rw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0]  wb_rd [5] = '{5'd3, 5'd3, 5'd3, 5'd8, 5'd2};
    logic [31:0] wb_d  [5] = '{32'h11, 32'h11, 32'h11, 32'h11, 32'hBB};
    logic [31:0] e1    [5] = '{32'h55, 32'h11, 32'h11, 32'h100, 32'h100};
    logic [31:0] e2    [5] = '{32'h7, 32'h7, 32'hAA, 32'h7, 32'hAA};
    obs_t got, exp;
    do_reset();
    id_instr(5'd3, 5'd2, 5'd4, 32'h100, 32'h7, 32'h20, ALU_ADD, 0, 1, 0, 0, 1, 0);
    tick();
    id_idle();
    for (int i = 0; i < 5; i++) begin
      exmem_reg_write_i = ex_rw[i]; exmem_rd_i = ex_rd[i]; exmem_data_i = ex_d[i];
      memwb_reg_write_i = wb_rw[i]; memwb_rd_i = wb_rd[i]; memwb_data_i = wb_d[i];
      exp_q.push_back(mk(1, ALU_ADD, e1[i], e2[i], e2[i], 5'd4, 0, 0, 1, 0));
      #1;
      got = observe(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL fwd_case%0d got=%h exp=%h", i, got, exp); end
    end
    fwd_clear();
    id_instr(5'd3, 5'd2, 5'd0, 32'h100, 32'h7, 32'h40, ALU_SW, 1, 1, 0, 1, 0, 0);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd2; exmem_data_i = 32'h99;
    exp_q.push_back(mk(1, ALU_SW, 32'h100, 32'h40, 32'h99, 5'd0, 0, 1, 0, 0));
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL fwd_store got=%h exp=%h", got, exp); end
  endtask

  task automatic test_x0_guard();
    obs_t got, exp;
    do_reset();
    id_instr(5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h5, ALU_ADDI, 1, 0, 0, 0, 1, 0);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd0; exmem_data_i = 32'hDEAD;
    memwb_reg_write_i = 1; memwb_rd_i = 5'd0; memwb_data_i = 32'hBEEF;
    exp_q.push_back(mk(1, ALU_ADDI, 32'h0, 32'h5, 32'h0, 5'd7, 0, 0, 1, 0));
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL x0_guard got=%h exp=%h", got, exp); end
    fwd_clear();
  endtask

  task automatic test_load_use();
    obs_t got, exp;
    do_reset();
    id_instr(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, ALU_LW, 1, 0, 1, 0, 1, 1);
    exp_q.push_back(mk(1, ALU_LW, 32'h1000, 32'h8, 32'h0, 5'd5, 1, 0, 1, 1));
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL lu_load got=%h exp=%h", got, exp); end
    id_instr(5'd6, 5'd5, 5'd7, 32'h3, 32'h4, 32'h0, ALU_ADD, 0, 1, 0, 0, 1, 0);
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL lu_hazard got=%b exp=1", hazard_o); end
    exp_q.push_back('0);
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", got, exp); end
    checks++; if (bubble_cnt_o !== 2'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", bubble_cnt_o); end
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_hazard_clear got=%b exp=0", hazard_o); end
    exp_q.push_back(mk(1, ALU_ADD, 32'h3, 32'h4, 32'h4, 5'd7, 0, 0, 1, 0));
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL lu_reload got=%h exp=%h", got, exp); end
    id_instr(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, ALU_LW, 1, 0, 1, 0, 1, 1);
    tick();
    id_instr(5'd6, 5'd5, 5'd7, 32'h3, 32'h4, 32'h0, ALU_ADDI, 1, 0, 0, 0, 1, 0);
    #1;
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_rs2_unused got=%b exp=0", hazard_o); end
    id_rs1_i = 5'd5; id_valid_i = 0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_id_invalid got=%b exp=0", hazard_o); end
    id_valid_i = 1;
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL lu_rs1_match got=%b exp=1", hazard_o); end
    flush_i = 1;
    #1;
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_flush_mask got=%b exp=0", hazard_o); end
    tick();
    flush_i = 0;
    checks++; if (ex_valid_o !== 1'b0 || bubble_cnt_o !== 2'd1) begin
      failures++; $display("FAIL lu_flush_nocount got=%b/%0d exp=0/1", ex_valid_o, bubble_cnt_o);
    end
  endtask

  task automatic test_stall_flush();
    obs_t got, exp;
    do_reset();
    id_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, ALU_SUB, 0, 1, 0, 0, 1, 0);
    exp_q.push_back(mk(1, ALU_SUB, 32'h11, 32'h22, 32'h22, 5'd3, 0, 0, 1, 0));
    tick();
    got = observe(); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL sf_load got=%h exp=%h", got, exp); end
    stall_i = 1;
    id_instr(5'd8, 5'd9, 5'd10, 32'h77, 32'h88, 32'h99, ALU_XOR, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1, ALU_SUB, 32'h11, 32'h22, 32'h22, 5'd3, 0, 0, 1, 0));
      tick();
      got = observe(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL sf_stall%0d got=%h exp=%h", i, got, exp); end
    end
    stall_i = 0;
    id_instr(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, ALU_LW, 1, 0, 1, 0, 1, 1);
    tick();
    stall_i = 1;
    id_instr(5'd5, 5'd0, 5'd7, 32'h3, 32'h4, 32'h0, ALU_ADDI, 1, 0, 0, 0, 1, 0);
    tick();
    tick();
    checks++; if (ex_valid_o !== 1'b1 || ex_mem_read_o !== 1'b1 || bubble_cnt_o !== 2'd0) begin
      failures++; $display("FAIL sf_stall_hazard got=%b%b/%0d exp=11/0", ex_valid_o, ex_mem_read_o, bubble_cnt_o);
    end
    flush_i = 1;
    tick();
    stall_i = 0; flush_i = 0;
    checks++; if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0) begin
      failures++; $display("FAIL sf_flush_wins got=%b%b exp=00", ex_valid_o, ex_reg_write_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      id_instr(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, ALU_LW, 1, 0, 1, 0, 1, 1);
      tick();
      id_instr(5'd5, 5'd0, 5'd7, 32'h3, 32'h4, 32'h0, ALU_ADDI, 1, 0, 0, 0, 1, 0);
      tick();
      exp_cnt = (i < 3) ? 2'(i) : 2'd3;
      checks++; if (bubble_cnt_o !== exp_cnt) begin
        failures++; $display("FAIL sat_bubble%0d got=%0d exp=%0d", i, bubble_cnt_o, exp_cnt);
      end
    end
    id_idle();
    tick();
    tick();
    checks++; if (bubble_cnt_o !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", bubble_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_x0_guard();
    test_load_use();
    test_stall_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
